switch_debounce: RTL and testbench

Synchronizes and debounces the eight raw front-panel switch inputs before they reach the bussed switch read port, which inverts them onto the data bus. Each bit passes through a two-flop synchronizer. A bit's output changes only after its synchronized input has held a different value for a programmable number of sample ticks. A one-cycle change strobe and per-bit change mask let bus logic detect new switch settings without polling.

---
 rtl/switch_debounce.sv | 68 ++++++
 tb/tb_switch_debounce.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: two-flop sync and tick-counted debounce of eight switches; SWITCH_DEBOUNCE_IRQ_EN adds sticky pending/irq
module switch_debounce #(
  parameter int         TICK_DIV     = 50000,
  parameter int         STABLE_COUNT = 4,
  parameter logic [8:1] RESET_VALUE  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:1] raw_switches,
  output logic [8:1] sw_out,
  output logic       changed,
  output logic [8:1] change_mask,
  input  logic       ack,
  output logic       irq
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_COUNT + 1);
  logic [8:1]         sync1_q, sync2_q, sw_q, sw_d, mask_d, mask_q;
  logic               changed_q, tick;
  logic [PW-1:0]      presc_q, presc_d;
  logic [8:1][CW-1:0] cnt_q, cnt_d;
  assign tick    = presc_q == PW'(TICK_DIV - 1);
  assign presc_d = tick ? '0 : presc_q + PW'(1);
  for (genvar g = 1; g <= 8; g++) begin : g_bit
    logic diff, done;
    assign diff     = sync2_q[g] != sw_q[g];
    assign done     = diff && tick && cnt_q[g] == CW'(STABLE_COUNT - 1);
    assign sw_d[g]  = done ? sync2_q[g] : sw_q[g];
    assign cnt_d[g] = (!diff || done) ? '0 : tick ? cnt_q[g] + CW'(1) : cnt_q[g];
  end
  assign mask_d      = sw_d ^ sw_q;
  assign sw_out      = sw_q;
  assign changed     = changed_q;
  assign change_mask = mask_q;
  // synchronizer, prescaler, stability counters and registered change report
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= RESET_VALUE;
      sync2_q   <= RESET_VALUE;
      presc_q   <= '0;
      cnt_q     <= '0;
      sw_q      <= RESET_VALUE;
      changed_q <= 1'b0;
      mask_q    <= '0;
    end else begin
      sync1_q   <= raw_switches;
      sync2_q   <= sync1_q;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      sw_q      <= sw_d;
      changed_q <= |mask_d;
      mask_q    <= mask_d;
    end
  end
`ifdef SWITCH_DEBOUNCE_IRQ_EN
  logic [8:1] pending_q;
  // sticky pending bits; a change arriving with ack survives the clear
  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else pending_q <= (ack ? 8'h00 : pending_q) | (changed_q ? mask_q : 8'h00);
  end
  assign irq = |pending_q;
`else
  logic unused_ack;
  assign unused_ack = ack;
  assign irq        = 1'b0;
`endif
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: random and directed stimulus checked against a tick-counting reference model
module tb_switch_debounce;
  localparam int TD = 4;
  localparam int SC = 3;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [8:1] raw_switches = 8'hFF;
  logic       ack = 1'b0;
  logic [8:1] sw_out, change_mask;
  logic       changed, irq;
  int total = 0;
  int bad = 0;
  logic [8:1] exp_sw, exp_mask, exp_pend, p1, p2;
  logic       exp_chg, ack_next;
  int         n;
  int         run [8];

  switch_debounce #(.TICK_DIV(TD), .STABLE_COUNT(SC), .RESET_VALUE(8'hFF)) dut (
    .clk(clk), .reset(reset), .raw_switches(raw_switches), .sw_out(sw_out),
    .changed(changed), .change_mask(change_mask), .ack(ack), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:1] got, input logic [8:1] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_sw = 8'hFF; exp_mask = 8'h00; exp_pend = 8'h00; exp_chg = 1'b0;
    p1 = 8'hFF; p2 = 8'hFF; n = 0;
    for (int i = 0; i < 8; i++) run[i] = 0;
  endtask

  // pins reach the debounce logic two edges late; a bit flips once it has differed for SC ticks in a row
  task automatic model_edge();
    logic [8:1] seen, nsw, m;
    bit tk;
    tk = (n % TD) == TD - 1;
    n++;
    seen = p2; p2 = p1; p1 = raw_switches;
    nsw = exp_sw;
    for (int i = 0; i < 8; i++) begin
      m = 8'(1 << i);
      if ((seen & m) == (exp_sw & m)) run[i] = 0;
      else if (tk) begin
        run[i]++;
        if (run[i] == SC) begin
          nsw = (nsw & ~m) | (seen & m);
          run[i] = 0;
        end
      end
    end
    exp_pend = (ack ? 8'h00 : exp_pend) | (exp_chg ? exp_mask : 8'h00);
    exp_mask = nsw ^ exp_sw;
    exp_chg  = exp_mask != 0;
    exp_sw   = nsw;
  endtask

  task automatic check_all();
    logic exp_irq;
`ifdef SWITCH_DEBOUNCE_IRQ_EN
    exp_irq = exp_pend != 0;
`else
    exp_irq = 1'b0;
`endif
    chk("sw_out", sw_out, exp_sw);
    chk("changed", {7'b0, changed}, {7'b0, exp_chg});
    chk("change_mask", change_mask, exp_mask);
    chk("irq", {7'b0, irq}, {7'b0, exp_irq});
  endtask

  task automatic step(input logic [8:1] v, input logic a);
    raw_switches = v;
    ack = a;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    ack = 1'b0;
    @(posedge clk);
    model_reset();
    #1 check_all();
    reset = 1'b0;
  endtask

  task automatic hold(input logic [8:1] v, input int cycles);
    for (int k = 0; k < cycles; k++) step(v, 1'b0);
  endtask

  // acks exactly in the cycle the model says a change pulse is showing
  task automatic hold_ack_on_change(input logic [8:1] v, input int cycles);
    ack_next = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      step(v, ack_next);
      ack_next = exp_chg;
    end
  endtask

  initial begin
    do_reset();
    hold(8'hFF, 40);
    chk("t1_idle", sw_out, 8'hFF);
    hold(8'hFE, 14);
    chk("t2_latency", sw_out, 8'hFE);
    hold(8'hFE, 6);
    hold(8'hFF, 20);
    hold(8'hFB, 6);
    hold(8'hFF, 20);
    chk("t3_glitch", sw_out, 8'hFF);
    hold(8'h7E, 20);
    chk("t4_pair", sw_out, 8'h7E);
    hold(8'hFF, 20);
    do_reset();
    hold(8'hFD, 11);
    do_reset();
    chk("t5_reset", sw_out, 8'hFF);
    hold(8'hFD, 20);
    chk("t5_reflip", sw_out, 8'hFD);
    hold(8'hFF, 20);
    hold(8'hFE, 20);
    hold_ack_on_change(8'hEE, 20);
    hold(8'hEE, 5);
    step(8'hEE, 1'b1);
    hold(8'hEE, 3);
    chk("t6_final", sw_out, 8'hEE);
    for (int r = 0; r < 60; r++) begin
      logic [8:1] v;
      v = 8'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        hold(v, $urandom_range(1, 8));
        v = exp_sw;
      end
      for (int k = $urandom_range(1, 20); k > 0; k--) step(v, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) do_reset();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
